fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/msriscv32_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/msriscv32_pkg.sv
// Shared constants for the instruction fetch path.
// Contents: AHB HTRANS encodings, the NOP instruction encoding, fetch
// fault-cause codes, the fetch FSM state encoding and the queue entry layout.
package msriscv32_pkg;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic CAUSE_BUS_ERR    = 1'b0;
  localparam logic CAUSE_MISALIGNED = 1'b1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fq_state_e;

  // 65-bit queue entry. The fault cause is not stored: bus beats are always
  // word aligned, so a faulting entry with a misaligned PC must be a
  // misaligned-redirect fault.
  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instruction entries.
// Ports:
//   clk_in, rst_in   clock, synchronous active-low reset
//   flush            empty the queue; a push in the same cycle still lands
//   push/wdata       write an entry (allowed when full if popping too)
//   pop/rdata        read data is the current head; pop advances it
//   full/empty/count occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (flush || !full || do_pop);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      cnt    <= do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[flush ? '0 : wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: AHB-Lite master issuing single NONSEQ reads and a
// queue of fetched instructions presented to the decoder.
// Ports:
//   clk_in, rst_in                      clock, synchronous active-low reset
//   redirect_in, redirect_pc_in         branch/trap/mret redirect and target
//   imaddr_out, htrans_out              AHB address phase
//   instr_in, hready_in, hresp_in       AHB data phase
//   instr_out, instr_pc_out,
//   instr_valid_out, instr_ready_in     queue head handshake
//   fault_out, fault_cause_out          head is a fault (0 bus, 1 misaligned)
//
// state    | meaning
// ST_FETCH | issuing reads while queue + in-flight beats leave room
// ST_HOLD  | queue full, waiting for a pop
// ST_FAULT | fault entry queued, no bus traffic until a redirect
module fetch_queue
  import msriscv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] imaddr_out,
  output logic [1:0]  htrans_out,
  input  logic [31:0] instr_in,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic        fault_out,
  output logic        fault_cause_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e   state, state_nxt;
  logic [31:0] addr;
  logic [31:0] pend_pc;
  logic        pending;
  logic        drop;

  logic          full, empty;
  logic [CW-1:0] count;
  fq_entry_t     head, wentry;

  logic        head_valid, pop, issue, addr_done, data_done;
  logic        beat_push, err_push, misalign, push;
  logic [CW:0] occ;

  assign misalign   = redirect_in && (redirect_pc_in[1:0] != 2'b00);
  assign head_valid = rst_in && !empty;
  assign pop        = head_valid && instr_ready_in;

  // Occupancy seen by a new request: queued entries, minus this cycle's pop,
  // plus the beat already in its data phase.
  assign occ   = (CW+1)'(count) + (CW+1)'(pending) - (CW+1)'(pop);
  assign issue = rst_in && (state == ST_FETCH) && (occ < (CW+1)'(DEPTH));

  assign addr_done = issue && hready_in;
  assign data_done = pending && hready_in;
  assign beat_push = data_done && !drop && !redirect_in && (state != ST_FAULT);
  assign err_push  = beat_push && hresp_in;
  assign push      = beat_push || misalign;

  always_comb begin
    wentry = '{fault: hresp_in, pc: pend_pc, instr: instr_in};
    if (misalign) wentry = '{fault: 1'b1, pc: redirect_pc_in, instr: NOP_INSTR};
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(65)) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (redirect_in),
    .push   (push),
    .pop    (pop),
    .wdata  (wentry),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= ST_FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_in) begin
      state_nxt = misalign ? ST_FAULT : ST_FETCH;
    end else if (err_push) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_FETCH: if (full && !pop) state_nxt = ST_HOLD;
        ST_HOLD:  if (pop) state_nxt = ST_FETCH;
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_FETCH;
      endcase
    end
  end

  // A beat still stalled in its data phase keeps its slot but is tagged for
  // discard if a redirect arrives; a beat issued alongside a redirect or an
  // error push is tagged the same way.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr    <= RESET_PC;
      pend_pc <= '0;
      pending <= 1'b0;
      drop    <= 1'b0;
    end else begin
      if (redirect_in)    addr <= redirect_pc_in;
      else if (addr_done) addr <= addr + 32'd4;

      if (pending && !hready_in) begin
        drop <= drop || redirect_in;
      end else begin
        pending <= addr_done;
        pend_pc <= addr;
        drop    <= addr_done && (redirect_in || err_push);
      end
    end
  end

  assign imaddr_out      = addr;
  assign htrans_out      = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign instr_valid_out = head_valid;
  assign instr_out       = head_valid ? head.instr : NOP_INSTR;
  assign instr_pc_out    = head_valid ? head.pc : 32'h0;
  assign fault_out       = head_valid && head.fault;
  assign fault_cause_out = (head_valid && head.fault && (head.pc[1:0] != 2'b00))
                           ? CAUSE_MISALIGNED : CAUSE_BUS_ERR;

endmodule
